// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants, pointer type and flag helpers for the FIFO core.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int unsigned c_DEFAULT_SIZE    = 8;
    localparam int unsigned c_DEFAULT_WIDTH   = 8;
    localparam int unsigned c_DEFAULT_PTR_LEN = $clog2(c_DEFAULT_SIZE);

    typedef logic [c_DEFAULT_PTR_LEN:0] ptr_t;

    // Pointers are passed zero-extended; full means only the wrap bit differs.
    function automatic logic is_full(input logic [31:0] rd,
                                     input logic [31:0] wr,
                                     input int unsigned ptr_len);
        return (rd ^ wr) == (32'd1 << ptr_len);
    endfunction

    function automatic logic is_empty(input logic [31:0] rd,
                                      input logic [31:0] wr);
        return rd == wr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_bram_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_bram_core_if
//  Description : Write/read handshake, data and status bundle of the FIFO core.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_bram_core_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PTR_LEN = 3
);

    logic               w_en;
    logic [WIDTH-1:0]   data_in;
    logic               r_en;
    logic [WIDTH-1:0]   data_out;
    logic               full;
    logic               empty;
    logic [PTR_LEN:0]   rd_ptr;
    logic [PTR_LEN:0]   wr_ptr;

    modport master (
        output w_en, data_in, r_en,
        input  data_out, full, empty, rd_ptr, wr_ptr
    );

    modport slave (
        input  w_en, data_in, r_en,
        output data_out, full, empty, rd_ptr, wr_ptr
    );

endinterface
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ptr
//  Description : Wrapping binary pointer with one extra wrap bit; holds when blocked.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr #(
    parameter int unsigned PTR_LEN = 3
) (
    input  wire logic             clk,
    input  wire logic             srstn,
    input  wire logic             inc_en,
    input  wire logic             blocked,
    output      logic [PTR_LEN:0] ptr
);

    localparam logic [PTR_LEN:0] c_ONE = {{PTR_LEN{1'b0}}, 1'b1};

    logic [PTR_LEN:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_ptr <= '0;
        end else if (inc_en && !blocked) begin
            r_ptr <= r_ptr + c_ONE;
        end
    end

    assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/fifo_bram_core.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_bram_core
//  Description : Single-clock FIFO with register-array storage, registered read
//                data and pointer-derived full/empty flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_bram_core
    import fifo_pkg::*;
#(
    parameter int unsigned SIZE  = c_DEFAULT_SIZE,
    parameter int unsigned WIDTH = c_DEFAULT_WIDTH
) (
    input  wire logic          clk,
    input  wire logic          srstn,
    fifo_bram_core_if.slave    bus
);

    localparam int unsigned c_PTR_LEN = $clog2(SIZE);

    logic [WIDTH-1:0]   r_mem [SIZE];
    logic [WIDTH-1:0]   r_data_out;
    logic [c_PTR_LEN:0] w_rd_ptr;
    logic [c_PTR_LEN:0] w_wr_ptr;
    logic               w_full;
    logic               w_empty;
    logic               w_wr_accept;
    logic               w_rd_accept;

    assign w_full      = is_full(32'(w_rd_ptr), 32'(w_wr_ptr), c_PTR_LEN);
    assign w_empty     = is_empty(32'(w_rd_ptr), 32'(w_wr_ptr));
    assign w_wr_accept = bus.w_en && !w_full;
    assign w_rd_accept = bus.r_en && !w_empty;

    fifo_ptr #(
        .PTR_LEN (c_PTR_LEN)
    ) u_rd_ptr (
        .clk     (clk),
        .srstn   (srstn),
        .inc_en  (bus.r_en),
        .blocked (w_empty),
        .ptr     (w_rd_ptr)
    );

    fifo_ptr #(
        .PTR_LEN (c_PTR_LEN)
    ) u_wr_ptr (
        .clk     (clk),
        .srstn   (srstn),
        .inc_en  (bus.w_en),
        .blocked (w_full),
        .ptr     (w_wr_ptr)
    );

    // Same-address write and read never coincide: matching addresses imply full or empty.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            for (int i = 0; i < int'(SIZE); i++) begin
                r_mem[i] <= '0;
            end
            r_data_out <= '0;
        end else begin
            if (w_wr_accept) begin
                r_mem[w_wr_ptr[c_PTR_LEN-1:0]] <= bus.data_in;
            end
            if (w_rd_accept) begin
                r_data_out <= r_mem[w_rd_ptr[c_PTR_LEN-1:0]];
            end
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.rd_ptr   = w_rd_ptr;
    assign bus.wr_ptr   = w_wr_ptr;

endmodule
`default_nettype wire

// File: tb/tb_fifo_bram_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_bram_core
//  Description : Scenario-driven bench for fifo_bram_core with a queue scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_bram_core;

    logic clk;
    logic srstn;

    int checks;
    int failures;

    logic [7:0] sb_q[$];
    logic [3:0] m_rd;
    logic [3:0] m_wr;
    logic [7:0] m_dout;

    fifo_bram_core_if #(.WIDTH(8), .PTR_LEN(3)) bus ();

    fifo_bram_core #(
        .SIZE  (8),
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .srstn (srstn),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; the scoreboard decides acceptance from occupancy before the edge.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r);
        bit wa;
        bit ra;
        wa = w && (sb_q.size() < 8);
        ra = r && (sb_q.size() > 0);
        bus.w_en    = w;
        bus.data_in = d;
        bus.r_en    = r;
        @(posedge clk);
        #1;
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
        if (ra) begin
            m_dout = sb_q.pop_front();
            m_rd   = m_rd + 4'd1;
        end
        if (wa) begin
            sb_q.push_back(d);
            m_wr = m_wr + 4'd1;
        end
    endtask

    task automatic model_clear();
        sb_q.delete();
        m_rd   = '0;
        m_wr   = '0;
        m_dout = '0;
    endtask

    task automatic test_reset();
        srstn       = 1'b0;
        bus.w_en    = 1'b0;
        bus.r_en    = 1'b0;
        bus.data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        srstn = 1'b1;
        model_clear();
        checks++;
        if (bus.empty !== 1'b1) begin
            failures++; $display("FAIL reset_empty: got %b want 1", bus.empty);
        end
        checks++;
        if (bus.full !== 1'b0) begin
            failures++; $display("FAIL reset_full: got %b want 0", bus.full);
        end
        checks++;
        if (bus.rd_ptr !== 4'd0 || bus.wr_ptr !== 4'd0) begin
            failures++; $display("FAIL reset_ptrs: got rd=%h wr=%h want 0/0", bus.rd_ptr, bus.wr_ptr);
        end
        checks++;
        if (bus.data_out !== 8'h00) begin
            failures++; $display("FAIL reset_dout: got %h want 00", bus.data_out);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            checks++;
            if (bus.wr_ptr !== m_wr || bus.empty !== 1'b0) begin
                failures++; $display("FAIL fill_wr_ptr[%0d]: got wr=%h empty=%b want wr=%h empty=0", i, bus.wr_ptr, bus.empty, m_wr);
            end
            checks++;
            if (bus.full !== (i == 8)) begin
                failures++; $display("FAIL fill_full[%0d]: got %b want %b", i, bus.full, (i == 8));
            end
        end
        checks++;
        if (bus.wr_ptr !== 4'b1000) begin
            failures++; $display("FAIL fill_wr_ptr_final: got %b want 1000", bus.wr_ptr);
        end
        cycle(1'b1, 8'hFF, 1'b0);
        checks++;
        if (bus.wr_ptr !== 4'b1000 || bus.full !== 1'b1) begin
            failures++; $display("FAIL overflow: got wr=%b full=%b want wr=1000 full=1", bus.wr_ptr, bus.full);
        end
    endtask

    task automatic test_drain_underflow();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++;
            if (bus.data_out !== m_dout || bus.data_out !== 8'(i)) begin
                failures++; $display("FAIL drain_data[%0d]: got %h want %h", i, bus.data_out, m_dout);
            end
            checks++;
            if (bus.rd_ptr !== m_rd) begin
                failures++; $display("FAIL drain_rd_ptr[%0d]: got %h want %h", i, bus.rd_ptr, m_rd);
            end
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            failures++; $display("FAIL drain_empty: got empty=%b full=%b want 1/0", bus.empty, bus.full);
        end
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus.data_out !== 8'h08 || bus.rd_ptr !== 4'b1000) begin
            failures++; $display("FAIL underflow: got dout=%h rd=%b want 08/1000", bus.data_out, bus.rd_ptr);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 8'hA0 + 8'(i), 1'b0);
            checks++;
            if (bus.full !== 1'b0) begin
                failures++; $display("FAIL wrap_full[%0d]: got %b want 0", i, bus.full);
            end
            cycle(1'b0, 8'h00, 1'b1);
            checks++;
            if (bus.data_out !== m_dout || bus.data_out !== 8'hA0 + 8'(i)) begin
                failures++; $display("FAIL wrap_data[%0d]: got %h want %h", i, bus.data_out, 8'hA0 + 8'(i));
            end
            checks++;
            if (bus.rd_ptr !== m_rd || bus.wr_ptr !== m_wr) begin
                failures++; $display("FAIL wrap_ptrs[%0d]: got rd=%b wr=%b want %b/%b", i, bus.rd_ptr, bus.wr_ptr, m_rd, m_wr);
            end
        end
        // Started at 1000; the 8th increment wraps the MSB back to 0, ending at 0100.
        checks++;
        if (bus.rd_ptr !== 4'b0100 || bus.empty !== 1'b1) begin
            failures++; $display("FAIL wrap_final: got rd=%b empty=%b want 0100/1", bus.rd_ptr, bus.empty);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] dout_before;
        logic [3:0] rd_before;
        dout_before = bus.data_out;
        rd_before   = bus.rd_ptr;
        cycle(1'b1, 8'h55, 1'b1);
        checks++;
        if (bus.rd_ptr !== rd_before || bus.data_out !== dout_before || bus.wr_ptr !== m_wr || bus.empty !== 1'b0) begin
            failures++; $display("FAIL simul_empty: got rd=%b wr=%b dout=%h empty=%b want rd=%b wr=%b dout=%h empty=0",
                                 bus.rd_ptr, bus.wr_ptr, bus.data_out, bus.empty, rd_before, m_wr, dout_before);
        end
        for (int i = 1; i <= 7; i++) begin
            cycle(1'b1, 8'h60 + 8'(i), 1'b0);
        end
        checks++;
        if (bus.full !== 1'b1) begin
            failures++; $display("FAIL simul_prefill_full: got %b want 1", bus.full);
        end
        cycle(1'b1, 8'h77, 1'b1);
        checks++;
        if (bus.data_out !== 8'h55 || bus.full !== 1'b0 || bus.wr_ptr !== m_wr || bus.rd_ptr !== m_rd) begin
            failures++; $display("FAIL simul_full: got dout=%h full=%b wr=%b rd=%b want 55/0/%b/%b",
                                 bus.data_out, bus.full, bus.wr_ptr, bus.rd_ptr, m_wr, m_rd);
        end
        cycle(1'b1, 8'h78, 1'b1);
        checks++;
        if (bus.data_out !== m_dout || bus.wr_ptr !== m_wr || bus.rd_ptr !== m_rd || bus.full !== 1'b0) begin
            failures++; $display("FAIL simul_both: got dout=%h wr=%b rd=%b want %h/%b/%b",
                                 bus.data_out, bus.wr_ptr, bus.rd_ptr, m_dout, m_wr, m_rd);
        end
        while (sb_q.size() > 0) begin
            cycle(1'b0, 8'h00, 1'b1);
            checks++;
            if (bus.data_out !== m_dout) begin
                failures++; $display("FAIL simul_drain: got %h want %h", bus.data_out, m_dout);
            end
        end
        checks++;
        if (bus.empty !== 1'b1) begin
            failures++; $display("FAIL simul_drain_empty: got %b want 1", bus.empty);
        end
    endtask

    task automatic test_midop_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'hC0 + 8'(i), 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus.data_out !== 8'hC0) begin
            failures++; $display("FAIL midop_pre_read: got %h want c0", bus.data_out);
        end
        srstn       = 1'b0;
        bus.w_en    = 1'b1;
        bus.data_in = 8'hEE;
        @(posedge clk);
        #1;
        srstn    = 1'b1;
        bus.w_en = 1'b0;
        model_clear();
        checks++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            failures++; $display("FAIL midop_flags: got empty=%b full=%b want 1/0", bus.empty, bus.full);
        end
        checks++;
        if (bus.rd_ptr !== 4'd0 || bus.wr_ptr !== 4'd0) begin
            failures++; $display("FAIL midop_ptrs: got rd=%h wr=%h want 0/0", bus.rd_ptr, bus.wr_ptr);
        end
        checks++;
        if (bus.data_out !== 8'h00) begin
            failures++; $display("FAIL midop_dout: got %h want 00", bus.data_out);
        end
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (bus.data_out !== m_dout || bus.data_out !== 8'h3C) begin
            failures++; $display("FAIL midop_resume: got %h want 3c", bus.data_out);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        srstn       = 1'b0;
        bus.w_en    = 1'b0;
        bus.r_en    = 1'b0;
        bus.data_in = '0;
        model_clear();
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_wrap();
        test_simultaneous();
        test_midop_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
